// File: rtl/dmem_access_ctrl.sv
// Data-RAM access sequencer for the MEM stage: latches a load/store, drives the
// RAM for LATENCY cycles, returns read data and stalls the pipeline meanwhile.
module dmem_access_ctrl #(
  parameter int unsigned LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_read,
  input  logic       mem_write,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       ram_en,
  output logic       ram_we,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_wdata,
  input  logic [7:0] ram_rdata,
  output logic [7:0] read_data,
  output logic       stall,
  output logic       mem_done,
  output logic       op_conflict
);

  // state | meaning
  // IDLE  | waiting for a load/store from EX/MEM
  // BUSY  | RAM access in flight, counter counts down to the last cycle
  // DONE  | access complete, mem_done pulses, pipeline released
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t     state, state_nxt;
  logic       req;
  logic       is_read;
  logic [3:0] count;

  assign req = mem_read | mem_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        stall = req;
        if (req) state_nxt = BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (count == 4'd0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A simultaneous read+write is resolved as a write; the conflict is remembered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= 8'h00;
      ram_wdata   <= 8'h00;
      read_data   <= 8'h00;
      mem_done    <= 1'b0;
      op_conflict <= 1'b0;
      is_read     <= 1'b0;
      count       <= 4'd0;
    end else begin
      mem_done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            ram_addr  <= addr;
            ram_wdata <= wdata;
            ram_en    <= 1'b1;
            ram_we    <= mem_write;
            is_read   <= ~mem_write;
            count     <= 4'(LATENCY - 1);
            if (mem_read && mem_write) op_conflict <= 1'b1;
          end
        end
        BUSY: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else begin
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
            mem_done <= 1'b1;
            if (is_read) read_data <= ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: a LATENCY=2 instance for the main
// scenarios and a LATENCY=1 instance for the short-latency build.
module tb_dmem_access_ctrl;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_read, mem_write;
  logic [7:0] addr, wdata;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata, ram_rdata, read_data;
  logic       stall, mem_done, op_conflict;

  logic       mem_read2, mem_write2;
  logic [7:0] addr2, wdata2;
  logic       ram_en2, ram_we2;
  logic [7:0] ram_addr2, ram_wdata2, ram_rdata2, read_data2;
  logic       stall2, mem_done2, op_conflict2;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] sb[$];

  logic [7:0] ram [256];
  bit ram_loaded = 1'b0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .read_data(read_data), .stall(stall), .mem_done(mem_done),
    .op_conflict(op_conflict));

  dmem_access_ctrl #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_read(mem_read2), .mem_write(mem_write2),
    .addr(addr2), .wdata(wdata2), .ram_en(ram_en2), .ram_we(ram_we2),
    .ram_addr(ram_addr2), .ram_wdata(ram_wdata2), .ram_rdata(ram_rdata2),
    .read_data(read_data2), .stall(stall2), .mem_done(mem_done2),
    .op_conflict(op_conflict2));

  // Behavioural RAM shared by both instances; only the LATENCY=2 one writes.
  assign ram_rdata  = ram[ram_addr];
  assign ram_rdata2 = ram[ram_addr2];

  always @(posedge clk) begin
    if (!ram_loaded) begin
      ram[8'h12] <= 8'hA5;
      ram[8'h7F] <= 8'h3C;
      ram_loaded <= 1'b1;
    end else if (ram_en && ram_we) begin
      ram[ram_addr] <= ram_wdata;
    end
  end

  task automatic go_idle();
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // Drives one access starting in the next cycle and checks it cycle by cycle.
  task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] wd, input logic [7:0] exp_rd);
    bit done;
    logic [7:0] exp;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; addr = a; wdata = wd;
    sb.push_back(exp_rd);
    @(negedge clk);
    n_checks++; if (stall !== 1'b1) $display("FAIL acc_c0_stall got %b want 1", stall); else n_pass++;
    done = 1'b0;
    for (int c = 1; c <= LAT + 4 && !done; c++) begin
      @(negedge clk);
      if (mem_done === 1'b1) begin
        done = 1'b1;
        n_checks++; if (c != LAT + 1) $display("FAIL acc_done_cycle got %0d want %0d", c, LAT + 1); else n_pass++;
        n_checks++; if (stall !== 1'b0) $display("FAIL acc_done_stall got %b want 0", stall); else n_pass++;
        n_checks++; if (ram_en !== 1'b0) $display("FAIL acc_done_ram_en got %b want 0", ram_en); else n_pass++;
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        n_checks++; if (read_data !== exp) $display("FAIL acc_read_data got %h want %h", read_data, exp); else n_pass++;
      end else begin
        n_checks++; if (stall !== 1'b1) $display("FAIL acc_busy_stall c%0d got %b want 1", c, stall); else n_pass++;
        n_checks++; if (ram_en !== 1'b1) $display("FAIL acc_busy_ram_en c%0d got %b want 1", c, ram_en); else n_pass++;
        n_checks++; if (ram_we !== wr) $display("FAIL acc_busy_ram_we c%0d got %b want %b", c, ram_we, wr); else n_pass++;
        n_checks++; if (ram_addr !== a) $display("FAIL acc_busy_ram_addr c%0d got %h want %h", c, ram_addr, a); else n_pass++;
        if (wr) begin
          n_checks++; if (ram_wdata !== wd) $display("FAIL acc_busy_ram_wdata c%0d got %h want %h", c, ram_wdata, wd); else n_pass++;
        end
      end
    end
    if (!done) begin
      n_checks++;
      $display("FAIL acc_timeout got no mem_done want pulse within %0d cycles", LAT + 4);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) $display("FAIL rst_stall got %b want 0", stall); else n_pass++;
    n_checks++; if ({ram_en, ram_we, mem_done, op_conflict} !== 4'b0) $display("FAIL rst_flags got %b want 0000", {ram_en, ram_we, mem_done, op_conflict}); else n_pass++;
    n_checks++; if ({ram_addr, ram_wdata, read_data} !== 24'h0) $display("FAIL rst_data got %h want 000000", {ram_addr, ram_wdata, read_data}); else n_pass++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++; if ({stall, ram_en, mem_done} !== 3'b000) $display("FAIL idle c%0d got %b want 000", i, {stall, ram_en, mem_done}); else n_pass++;
    end
  endtask

  task automatic test_load();
    access(1'b1, 1'b0, 8'h12, 8'h00, 8'hA5);
  endtask

  task automatic test_back_to_back();
    access(1'b0, 1'b1, 8'h34, 8'h5A, 8'hA5);
    access(1'b1, 1'b0, 8'h34, 8'h00, 8'h5A);
    go_idle();
  endtask

  task automatic test_conflict();
    @(negedge clk);
    n_checks++; if (op_conflict !== 1'b0) $display("FAIL conf_pre got %b want 0", op_conflict); else n_pass++;
    access(1'b1, 1'b1, 8'h01, 8'h77, 8'h5A);
    n_checks++; if (op_conflict !== 1'b1) $display("FAIL conf_set got %b want 1", op_conflict); else n_pass++;
    access(1'b1, 1'b0, 8'h01, 8'h00, 8'h77);
    go_idle();
    @(negedge clk);
    n_checks++; if (op_conflict !== 1'b1) $display("FAIL conf_sticky got %b want 1", op_conflict); else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    mem_read = 1'b1; mem_write = 1'b0; addr = 8'h12;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1; mem_read = 1'b0;
    #1;
    n_checks++; if (ram_en !== 1'b0) $display("FAIL rmid_ram_en got %b want 0", ram_en); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL rmid_stall got %b want 0", stall); else n_pass++;
    n_checks++; if (read_data !== 8'h00) $display("FAIL rmid_read_data got %h want 00", read_data); else n_pass++;
    n_checks++; if (op_conflict !== 1'b0) $display("FAIL rmid_conflict got %b want 0", op_conflict); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (mem_done !== 1'b0) $display("FAIL rmid_no_done c%0d got %b want 0", i, mem_done); else n_pass++;
    end
    rst = 1'b0;
    access(1'b1, 1'b0, 8'h12, 8'h00, 8'hA5);
    go_idle();
  endtask

  task automatic test_latency1();
    logic [7:0] exp;
    @(posedge clk); #1;
    mem_read2 = 1'b1; addr2 = 8'h7F;
    sb.push_back(8'h3C);
    @(negedge clk);
    n_checks++; if (stall2 !== 1'b1) $display("FAIL lat1_c0_stall got %b want 1", stall2); else n_pass++;
    @(negedge clk);
    n_checks++; if ({stall2, ram_en2, mem_done2} !== 3'b110) $display("FAIL lat1_c1 got %b want 110", {stall2, ram_en2, mem_done2}); else n_pass++;
    n_checks++; if (ram_addr2 !== 8'h7F) $display("FAIL lat1_addr got %h want 7f", ram_addr2); else n_pass++;
    @(negedge clk);
    n_checks++; if ({stall2, ram_en2, mem_done2} !== 3'b001) $display("FAIL lat1_c2 got %b want 001", {stall2, ram_en2, mem_done2}); else n_pass++;
    exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
    n_checks++; if (read_data2 !== exp) $display("FAIL lat1_read_data got %h want %h", read_data2, exp); else n_pass++;
    @(posedge clk); #1;
    mem_read2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; addr = 8'h00; wdata = 8'h00;
    mem_read2 = 1'b0; mem_write2 = 1'b0; addr2 = 8'h00; wdata2 = 8'h00;
    test_reset();
    test_idle();
    test_load();
    test_back_to_back();
    test_conflict();
    test_reset_mid();
    test_latency1();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
